// File: rtl/cfg_loader.sv
// Byte-serial config loader: HDR + 4 payload bytes become one 32-bit config write.
// Define CFG_CHECKSUM_EN to require a trailing XOR checksum byte in every frame.
module cfg_loader #(
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cfg_wen,
  output logic [31:0] cfg_data_out,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHK     = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_shadow, w_shadow_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_idle, w_idle_nxt;
  logic [31:0] r_cfg_data;
  logic        r_frame_err, w_frame_err_nxt;
  logic        w_load_cfg;
  logic        w_hs;
  logic        w_timeout;
  logic [7:0]  w_idle_inc;
  logic [7:0]  w_xor;

  assign byte_ready   = rst && (r_state != WRITE);
  assign w_hs         = byte_valid && byte_ready;
  assign w_idle_inc   = r_idle + 8'd1;
  // A handshake in the would-be timeout cycle takes priority over the abort.
  assign w_timeout    = !w_hs && (w_idle_inc == TIMEOUT_CNT);
  assign w_xor        = r_shadow[31:24] ^ r_shadow[23:16] ^ r_shadow[15:8] ^ r_shadow[7:0];

  assign cfg_wen      = (r_state == WRITE);
  assign busy         = (r_state != IDLE);
  assign frame_err    = r_frame_err;
  assign cfg_data_out = r_cfg_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_idx_nxt       = r_idx;
    w_idle_nxt      = 8'd0;
    w_frame_err_nxt = 1'b0;
    w_load_cfg      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_hs && (byte_in == HDR)) begin
          w_state_nxt = PAYLOAD;
          w_idx_nxt   = 2'd0;
        end
      end

      PAYLOAD: begin
        if (w_hs) begin
          w_shadow_nxt = {r_shadow[23:0], byte_in};
          w_idx_nxt    = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
`ifdef CFG_CHECKSUM_EN
            w_state_nxt = CHK;
`else
            w_state_nxt = WRITE;
            w_load_cfg  = 1'b1;
`endif
          end
        end else if (w_timeout) begin
          w_state_nxt     = IDLE;
          w_frame_err_nxt = 1'b1;
          w_shadow_nxt    = 32'h0;
          w_idx_nxt       = 2'd0;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end

      CHK: begin
        if (w_hs) begin
          if (byte_in == w_xor) begin
            w_state_nxt = WRITE;
            w_load_cfg  = 1'b1;
          end else begin
            w_state_nxt     = IDLE;
            w_frame_err_nxt = 1'b1;
            w_shadow_nxt    = 32'h0;
          end
        end else if (w_timeout) begin
          w_state_nxt     = IDLE;
          w_frame_err_nxt = 1'b1;
          w_shadow_nxt    = 32'h0;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end

      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The config word is loaded on the edge into WRITE so it is already valid while cfg_wen is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow    <= 32'h0;
      r_idx       <= 2'd0;
      r_idle      <= 8'd0;
      r_cfg_data  <= 32'h0;
      r_frame_err <= 1'b0;
    end else begin
      r_shadow    <= w_shadow_nxt;
      r_idx       <= w_idx_nxt;
      r_idle      <= w_idle_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (w_load_cfg) begin
        r_cfg_data <= w_shadow_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed testbench for cfg_loader: stimulus pushes expected writes/errors into a queue,
// a negedge monitor pops and compares them. Add +define+CFG_CHECKSUM_EN for the checksum build.
`timescale 1ns/1ps
module tb_cfg_loader;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        cfg_wen;
  logic [31:0] cfg_data_out;
  logic        busy;
  logic        frame_err;

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] held   = 32'h0;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  cfg_loader #(.HDR(HDR), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .cfg_wen      (cfg_wen),
    .cfg_data_out (cfg_data_out),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic is_err, input logic [31:0] data, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  // Drives one byte after 'gap' idle cycles; t returns the cycle in which the handshake happened.
  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    int budget;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
    end
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    budget     = 0;
    while (!byte_ready && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    check("hs_ready", byte_ready, 1'b1);
    t = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [7:0] ck, input logic ck_good);
    int   t;
    logic ok;
    send_byte(HDR, 0, t);
    #1 check("hdr_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 0, t);
`ifdef CFG_CHECKSUM_EN
    send_byte(ck, 0, t);
    ok = ck_good;
`else
    ok = 1'b1;
`endif
    push(!ok, w, t + 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) held = 32'h0;
    check("byte_ready", byte_ready, rst && !cfg_wen);
    if (cfg_wen || frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'h0, cfg_wen, frame_err}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("event_frame_err", frame_err, e.is_err);
        check("event_cfg_wen", cfg_wen, !e.is_err);
        check("event_cycle", cyc, e.at);
        if (!e.is_err) begin
          check("cfg_data", cfg_data_out, e.data);
          held = e.data;
        end else begin
          check("cfg_hold_on_err", cfg_data_out, held);
        end
      end
    end else begin
      check("cfg_hold", cfg_data_out, held);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", byte_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wen", cfg_wen, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_data", cfg_data_out, 32'h0);
    rst = 1'b1;

    // Non-header bytes in IDLE are dropped.
    send_byte(8'h00, 0, t); #1 check("junk_busy_00", busy, 1'b0);
    send_byte(8'hFF, 0, t); #1 check("junk_busy_ff", busy, 1'b0);
    send_byte(8'h5A, 0, t); #1 check("junk_busy_5a", busy, 1'b0);
    send_frame(32'h11223344, 8'h44, 1'b1);

    // Back-to-back frames with byte_valid held high.
    send_frame(32'hDEADBEEF, 8'h22, 1'b1);
    send_frame(32'h01020304, 8'h04, 1'b1);
    idle(3);

    // Bad checksum (or, without checksum, the trailing byte is a stray IDLE byte).
    send_frame(32'h11223344, 8'h45, 1'b0);
`ifdef CFG_CHECKSUM_EN
    idle(2);
    check("bad_ck_busy", busy, 1'b0);
`else
    send_byte(8'h45, 0, t);
    #1 check("stray_busy", busy, 1'b0);
`endif
    idle(2);

    // Header value inside the payload is data.
    send_frame(32'hA5A50F0F, 8'h00, 1'b1);
    idle(2);

    // Handshake in the cycle the counter would reach TIMEOUT wins.
    send_byte(HDR, 0, t);
    send_byte(8'h11, 0, t);
    send_byte(8'h22, TIMEOUT - 1, t);
    send_byte(8'h33, 0, t);
    send_byte(8'h44, 0, t);
`ifdef CFG_CHECKSUM_EN
    send_byte(8'h44, TIMEOUT - 1, t);
`endif
    push(1'b0, 32'h11223344, t + 1);
    idle(2);

    // Real timeout: frame_err one cycle after the 16th idle cycle.
    send_byte(HDR, 0, t);
    send_byte(8'h11, 0, t);
    push(1'b1, 32'h0, t + TIMEOUT + 1);
    idle(TIMEOUT + 3);
    check("timeout_busy", busy, 1'b0);
    send_frame(32'hCAFEF00D, 8'hC9, 1'b1);
    idle(2);

    // Reset mid-frame discards it silently.
    send_byte(HDR, 0, t);
    send_byte(8'h11, 0, t);
    send_byte(8'h22, 0, t);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", byte_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_wen", cfg_wen, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    check("midrst_data", cfg_data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_frame(32'h11223344, 8'h44, 1'b1);
    idle(3);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
